g_code_encoder: RTL and testbench
=================================

G_CODE_ENCODER -- requirements
Module: g_code_encoder

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-002 Port list (name  direction  width  meaning):
- i_Clock50MHz  in  1  — system clock, 50 MHz.
- i_Reset  in  1  — synchronous active-high reset.
- i_Start  in  1  — request to encode one line; sampled in IDLE only.
- i_FieldEnable  in  5  — field enables: bit0=X, bit1=Y, bit2=Z, bit3=E, bit4=F.
- i_XValue, i_YValue, i_ZValue, i_EValue, i_FValue  in  48 each  — ASCII-packed magnitude, six characters; [47:40] is the first character; 0x00 bytes are empty positions.
- i_XDirection, i_YDirection, i_ZDirection, i_EDirection  in  1 each  — 1 = negative.
- o_SerialData  out  8  — byte presented to the UART transmitter.
- o_SerialValid  out  1  — o_SerialData is valid.
- i_SerialAccept  in  1  — transmitter takes the byte this cycle.
- o_Busy  out  1  — line encoding in progress.
- o_LineDone  out  1  — one-cycle pulse after the CR byte is accepted.

Function
REQ-003 When i_Start=1 in IDLE, the block SHALL register all values, directions and i_FieldEnable in that cycle, and SHALL assert o_Busy from the next cycle.
REQ-004 The block SHALL ignore i_Start while o_Busy=1; changes to the inputs during a line SHALL have no effect.
REQ-005 Output byte sequence SHALL be:
- 'G' (71), '1' (49);
- then, for each enabled field in order X, Y, Z, E, F: ' ' (32), the letter (88/89/90/69/70), '-' (45) if the direction bit is 1 (never for F), then the characters;
- then CR (13).
REQ-006 Characters SHALL be emitted from [47:40] down to [7:0], skipping every 0x00 byte; if all six bytes are 0x00, a single '0' (48) SHALL be emitted.
REQ-007 When i_FieldEnable=0, the line SHALL be "G1" followed by CR.
REQ-008 Handshake:
- o_SerialData SHALL hold stable while o_SerialValid=1 and i_SerialAccept=0.
- A byte is transferred only in a cycle where o_SerialValid=1 and i_SerialAccept=1.
- The next byte (or o_SerialValid=0 after CR) SHALL appear in the following cycle.
- o_SerialValid SHALL never drop before acceptance.
REQ-009 The first byte ('G') SHALL be valid in the cycle after the i_Start cycle. With i_SerialAccept held at 1, the block SHALL sustain one byte per cycle with no gap cycles, including when skipping 0x00 bytes.
REQ-010 State machine states SHALL be: IDLE, HDR_G, HDR_1, SEP, LETTER, SIGN, CHARS, EOL, DONE. Each state advances only on acceptance, except DONE. Disabled fields and the SIGN state for a positive value SHALL be bypassed with no gap cycle.
REQ-011 DONE SHALL last exactly one cycle with o_LineDone=1, o_Busy=1 and o_SerialValid=0, then return to IDLE. A new i_Start is accepted from the first IDLE cycle.
REQ-012 The character-index counter SHALL be 3 bits, range 0..5, and SHALL restart at 0 for each field.

Reset
REQ-013 In any cycle with i_Reset=1, the block SHALL go to IDLE and set o_SerialValid=0, o_SerialData=0, o_Busy=0 and o_LineDone=0. All latched fields and counters SHALL be cleared.
REQ-014 Reset mid-line SHALL abandon the line. No CR and no o_LineDone SHALL be produced, and the next i_Start SHALL produce a complete fresh line.
REQ-015 i_Reset SHALL take priority over i_Start in the same cycle.

Verification
REQ-016 X=0x000000313230 ("120"), XDir=1, enable=0b00001, accept held at 1:
- bytes SHALL be 71,49,32,88,45,49,50,48,13 on 9 consecutive cycles;
- o_LineDone SHALL pulse once on the following cycle.
REQ-017 Enable=0b10110, Y=0x000000000035, Z=0, F=0x000000323530, all directions 0:
- output SHALL be "G1 Y5 Z0 F250" then CR (71,49,32,89,53,32,90,48,32,70,50,53,48,13).
REQ-018 Backpressure: accept toggles 1,0,0,1,... on the REQ-016 line:
- each byte SHALL stay stable through the stall cycles;
- the sequence SHALL be unchanged, and no byte SHALL be duplicated or dropped.
REQ-019 Pulse i_Start again during the line, and change i_XValue during the line:
- the output SHALL match the first request exactly;
- exactly one o_LineDone SHALL occur.
REQ-020 Assert i_Reset while the 4th byte is presented:
- o_SerialValid SHALL be 0 on the next cycle;
- a following i_Start SHALL emit the full line beginning with 'G'.
REQ-021 Enable=0 with i_Start:
- output SHALL be 71,49,13, then o_LineDone;
- i_Start in the first IDLE cycle after DONE SHALL be accepted.

Source files
------------

// File: rtl/g_code_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : g_code_encoder_if
//  Description : Bundle of the G-code encoder's request and byte-stream signals.
//                The slave modport is the encoder. The master modport is the
//                side that requests lines and consumes bytes.
//                  i_Start        - request to encode one line
//                  i_FieldEnable  - bit0=X bit1=Y bit2=Z bit3=E bit4=F
//                  i_?Value       - six ASCII characters, [47:40] first,
//                                   0x00 means empty position
//                  i_?Direction   - 1 = negative (no F direction)
//                  o_SerialData   - byte for the UART transmitter
//                  o_SerialValid  - o_SerialData is valid
//                  i_SerialAccept - transmitter takes the byte this cycle
//                  o_Busy         - line encoding in progress
//                  o_LineDone     - one-cycle pulse after CR is accepted
//  Revision    : 1.0 - initial release
// ============================================================================
interface g_code_encoder_if;
    logic        i_Start;
    logic [4:0]  i_FieldEnable;
    logic [47:0] i_XValue;
    logic [47:0] i_YValue;
    logic [47:0] i_ZValue;
    logic [47:0] i_EValue;
    logic [47:0] i_FValue;
    logic        i_XDirection;
    logic        i_YDirection;
    logic        i_ZDirection;
    logic        i_EDirection;
    logic [7:0]  o_SerialData;
    logic        o_SerialValid;
    logic        i_SerialAccept;
    logic        o_Busy;
    logic        o_LineDone;

    modport slave (
        input  i_Start, i_FieldEnable,
        input  i_XValue, i_YValue, i_ZValue, i_EValue, i_FValue,
        input  i_XDirection, i_YDirection, i_ZDirection, i_EDirection,
        input  i_SerialAccept,
        output o_SerialData, o_SerialValid, o_Busy, o_LineDone
    );

    modport master (
        output i_Start, i_FieldEnable,
        output i_XValue, i_YValue, i_ZValue, i_EValue, i_FValue,
        output i_XDirection, i_YDirection, i_ZDirection, i_EDirection,
        output i_SerialAccept,
        input  o_SerialData, o_SerialValid, o_Busy, o_LineDone
    );
endinterface
`default_nettype wire

// File: rtl/g_code_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : g_code_encoder
//  Description : Serialises one G1 move line ("G1 X-120 Y5 ... <CR>") as a
//                byte stream with a valid/accept handshake, one byte per cycle
//                when the transmitter always accepts.
//  Ports       : i_Clock50MHz - system clock
//                i_Reset      - synchronous active-high reset
//                bus          - g_code_encoder_if.slave (request, field
//                               values/directions, byte stream, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module g_code_encoder (
    input  wire logic        i_Clock50MHz,
    input  wire logic        i_Reset,
    g_code_encoder_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        HDR_G  = 4'd1,
        HDR_1  = 4'd2,
        SEP    = 4'd3,
        LETTER = 4'd4,
        SIGN   = 4'd5,
        CHARS  = 4'd6,
        EOL    = 4'd7,
        DONE   = 4'd8
    } state_t;

    localparam logic [7:0] c_char_g     = 8'd71;
    localparam logic [7:0] c_char_one   = 8'd49;
    localparam logic [7:0] c_char_space = 8'd32;
    localparam logic [7:0] c_char_minus = 8'd45;
    localparam logic [7:0] c_char_zero  = 8'd48;
    localparam logic [7:0] c_char_cr    = 8'd13;

    state_t      state_q, state_d;
    logic [2:0]  field_q, field_d;     // current field 0..4 = X,Y,Z,E,F
    logic [2:0]  idx_q,   idx_d;       // character position 0..5
    logic [4:0]  en_q,    en_d;
    logic [3:0]  dir_q,   dir_d;
    logic [47:0] val_q [5];
    logic [47:0] val_d [5];
    logic [7:0]  data_q,  data_d;
    logic        valid_q, valid_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    logic        w_adv;
    logic [47:0] w_cur_val;
    logic [7:0]  w_letter;
    logic        w_cur_neg;
    logic [2:0]  w_fld_from;
    logic        w_fld_found;
    logic [2:0]  w_fld_next;
    logic [2:0]  w_chr_from;
    logic        w_chr_found;
    logic [2:0]  w_chr_next;
    logic [7:0]  w_chr_byte;

    assign w_adv = valid_q && bus.i_SerialAccept;

    // Per-field selections for the field being emitted.
    always_comb begin
        w_cur_val = val_q[4];
        w_letter  = 8'd70;
        w_cur_neg = 1'b0;
        case (field_q)
            3'd0: begin w_cur_val = val_q[0]; w_letter = 8'd88; w_cur_neg = dir_q[0]; end
            3'd1: begin w_cur_val = val_q[1]; w_letter = 8'd89; w_cur_neg = dir_q[1]; end
            3'd2: begin w_cur_val = val_q[2]; w_letter = 8'd90; w_cur_neg = dir_q[2]; end
            3'd3: begin w_cur_val = val_q[3]; w_letter = 8'd69; w_cur_neg = dir_q[3]; end
            default: ;
        endcase
    end

    // Next enabled field at or after w_fld_from. Searching the whole range in
    // one cycle is what lets disabled fields cost no gap cycle.
    always_comb begin
        w_fld_from  = (state_q == HDR_1) ? 3'd0 : field_q + 3'd1;
        w_fld_found = 1'b0;
        w_fld_next  = 3'd0;
        for (int f = 4; f >= 0; f--) begin
            if (f >= int'(w_fld_from) && en_q[f]) begin
                w_fld_found = 1'b1;
                w_fld_next  = 3'(f);
            end
        end
    end

    // Next non-empty character position at or after w_chr_from; empty 0x00
    // positions are skipped within the same cycle.
    always_comb begin
        w_chr_from  = (state_q == CHARS) ? idx_q + 3'd1 : 3'd0;
        w_chr_found = 1'b0;
        w_chr_next  = 3'd0;
        w_chr_byte  = 8'd0;
        for (int p = 5; p >= 0; p--) begin
            if (p >= int'(w_chr_from) && w_cur_val[47-8*p -: 8] != 8'd0) begin
                w_chr_found = 1'b1;
                w_chr_next  = 3'(p);
                w_chr_byte  = w_cur_val[47-8*p -: 8];
            end
        end
    end

    // Next-state and next-output logic. The byte for a state is computed on
    // entry, so outputs come straight from flops.
    always_comb begin
        state_d = state_q;
        field_d = field_q;
        idx_d   = idx_q;
        en_d    = en_q;
        dir_d   = dir_q;
        val_d   = val_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_Start) begin
                    en_d     = bus.i_FieldEnable;
                    dir_d    = {bus.i_EDirection, bus.i_ZDirection,
                                bus.i_YDirection, bus.i_XDirection};
                    val_d[0] = bus.i_XValue;
                    val_d[1] = bus.i_YValue;
                    val_d[2] = bus.i_ZValue;
                    val_d[3] = bus.i_EValue;
                    val_d[4] = bus.i_FValue;
                    field_d  = 3'd0;
                    idx_d    = 3'd0;
                    state_d  = HDR_G;
                    data_d   = c_char_g;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            HDR_G: begin
                if (w_adv) begin
                    state_d = HDR_1;
                    data_d  = c_char_one;
                end
            end
            HDR_1, CHARS: begin
                if (w_adv) begin
                    if (state_q == CHARS && w_chr_found) begin
                        idx_d  = w_chr_next;
                        data_d = w_chr_byte;
                    end else if (w_fld_found) begin
                        state_d = SEP;
                        field_d = w_fld_next;
                        idx_d   = 3'd0;
                        data_d  = c_char_space;
                    end else begin
                        state_d = EOL;
                        idx_d   = 3'd0;
                        data_d  = c_char_cr;
                    end
                end
            end
            SEP: begin
                if (w_adv) begin
                    state_d = LETTER;
                    data_d  = w_letter;
                end
            end
            LETTER, SIGN: begin
                if (w_adv) begin
                    if (state_q == LETTER && w_cur_neg && field_q != 3'd4) begin
                        state_d = SIGN;
                        data_d  = c_char_minus;
                    end else begin
                        // An all-empty value still prints as a single '0'.
                        state_d = CHARS;
                        idx_d   = w_chr_found ? w_chr_next : 3'd0;
                        data_d  = w_chr_found ? w_chr_byte : c_char_zero;
                    end
                end
            end
            EOL: begin
                if (w_adv) begin
                    state_d = DONE;
                    data_d  = 8'd0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                data_d  = 8'd0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clock50MHz) begin
        if (i_Reset) begin
            state_q <= IDLE;
            field_q <= 3'd0;
            idx_q   <= 3'd0;
            en_q    <= 5'd0;
            dir_q   <= 4'd0;
            val_q   <= '{default: '0};
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            dir_q   <= dir_d;
            val_q   <= val_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_SerialData  = data_q;
    assign bus.o_SerialValid = valid_q;
    assign bus.o_Busy        = busy_q;
    assign bus.o_LineDone    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_g_code_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_g_code_encoder
//  Description : Self-checking bench for g_code_encoder. Expected bytes of each
//                requested line are queued when the request is driven and are
//                compared as the encoder hands them over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_g_code_encoder;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    g_code_encoder_if bus ();

    g_code_encoder u_dut (
        .i_Clock50MHz (clk),
        .i_Reset      (rst),
        .bus          (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          lines_expected = 0;
    logic [7:0]  exp_q [$];

    logic [4:0]  t_en;
    logic [47:0] t_val [5];
    logic [3:0]  t_dir;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] letter_of(input int f);
        case (f)
            0: return 8'd88;
            1: return 8'd89;
            2: return 8'd90;
            3: return 8'd69;
            default: return 8'd70;
        endcase
    endfunction

    // Reference model: builds the byte list of a line from the latched fields.
    task automatic push_expected(output int n);
        logic [7:0] b;
        int         nz;
        n = 0;
        exp_q.push_back(8'd71); n++;
        exp_q.push_back(8'd49); n++;
        for (int f = 0; f < 5; f++) begin
            if (t_en[f]) begin
                exp_q.push_back(8'd32); n++;
                exp_q.push_back(letter_of(f)); n++;
                if (f < 4 && t_dir[f]) begin exp_q.push_back(8'd45); n++; end
                nz = 0;
                for (int p = 0; p < 6; p++) begin
                    b = t_val[f][47-8*p -: 8];
                    if (b != 8'd0) begin exp_q.push_back(b); n++; nz++; end
                end
                if (nz == 0) begin exp_q.push_back(8'd48); n++; end
            end
        end
        exp_q.push_back(8'd13); n++;
    endtask

    task automatic set_fields(input logic [4:0] en, input logic [47:0] x, input logic [47:0] y,
                              input logic [47:0] z, input logic [47:0] e, input logic [47:0] f,
                              input logic [3:0] d);
        t_en = en; t_dir = d;
        t_val[0] = x; t_val[1] = y; t_val[2] = z; t_val[3] = e; t_val[4] = f;
        bus.i_FieldEnable = en;
        bus.i_XValue = x; bus.i_YValue = y; bus.i_ZValue = z;
        bus.i_EValue = e; bus.i_FValue = f;
        bus.i_XDirection = d[0]; bus.i_YDirection = d[1];
        bus.i_ZDirection = d[2]; bus.i_EDirection = d[3];
    endtask

    // Called just after a rising edge; leaves just after the edge that took i_Start.
    task automatic start_line(output int n);
        push_expected(n);
        bus.i_Start = 1'b1;
        @(posedge clk); #1;
        bus.i_Start = 1'b0;
        check_value("busy_after_start", 32'(bus.o_Busy), 1);
        check_value("valid_after_start", 32'(bus.o_SerialValid), 1);
    endtask

    // mode 0: always accept, 1: accept pattern 1,0,0, 2: random accept.
    task automatic run_line(input int mode, input bit disturb, output int cycles);
        cycles = 0;
        for (int k = 0; k < 400; k++) begin
            case (mode)
                0:       bus.i_SerialAccept = 1'b1;
                1:       bus.i_SerialAccept = (k % 3 == 0);
                default: bus.i_SerialAccept = 1'($urandom_range(0, 1));
            endcase
            if (disturb && k == 2) begin
                bus.i_Start  = 1'b1;
                bus.i_XValue = 48'h393939393939;
            end
            if (disturb && k == 3) bus.i_Start = 1'b0;
            @(posedge clk); #1;
            cycles++;
            if (bus.o_LineDone) return;
        end
        check_value("line_timeout", 0, 1);
    endtask

    function automatic logic [47:0] rand_val();
        logic [47:0] v;
        v = '0;
        for (int p = 0; p < 6; p++)
            if ($urandom_range(0, 1) == 1) v[47-8*p -: 8] = 8'(8'h30 + $urandom_range(0, 9));
        return v;
    endfunction

    // Monitor: pops on every transfer, checks stall stability and the done pulse.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_value("stall_valid_hold", 32'(bus.o_SerialValid), 1);
                check_value("stall_data_hold", 32'(bus.o_SerialData), 32'(prev_data));
            end
            if (bus.o_SerialValid && bus.i_SerialAccept) begin
                if (exp_q.size() == 0) check_value("unexpected_byte", 32'(bus.o_SerialData), 32'h100);
                else                   check_value("byte", 32'(bus.o_SerialData), 32'(exp_q.pop_front()));
            end
            if (bus.o_LineDone) begin
                done_cnt++;
                check_value("done_queue_empty", exp_q.size(), 0);
                check_value("done_valid_low", 32'(bus.o_SerialValid), 0);
                check_value("done_busy_high", 32'(bus.o_Busy), 1);
            end
            prev_stall = bus.o_SerialValid && !bus.i_SerialAccept;
            prev_data  = bus.o_SerialData;
        end
    end

    localparam logic [47:0] c_x120 = 48'h000000313230;

    initial begin
        int n, cyc, dc;
        rst = 1'b1;
        bus.i_Start = 1'b0;
        bus.i_SerialAccept = 1'b1;
        set_fields(5'd0, '0, '0, '0, '0, '0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_valid", 32'(bus.o_SerialValid), 0);
        check_value("rst_data", 32'(bus.o_SerialData), 0);
        check_value("rst_busy", 32'(bus.o_Busy), 0);
        check_value("rst_done", 32'(bus.o_LineDone), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset wins over a simultaneous start.
        set_fields(5'b00001, c_x120, '0, '0, '0, '0, 4'b0001);
        rst = 1'b1; bus.i_Start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.i_Start = 1'b0;
        @(posedge clk); #1;
        check_value("rst_start_busy", 32'(bus.o_Busy), 0);
        check_value("rst_start_valid", 32'(bus.o_SerialValid), 0);

        // "G1 X-120", full-rate.
        set_fields(5'b00001, c_x120, '0, '0, '0, '0, 4'b0001);
        start_line(n); run_line(0, 1'b0, cyc); lines_expected++;
        check_value("x120_len", cyc, 9);
        @(posedge clk); #1;

        // "G1 Y5 Z0 F250".
        set_fields(5'b10110, '0, 48'h000000000035, '0, '0, 48'h000000323530, 4'd0);
        start_line(n); run_line(0, 1'b0, cyc); lines_expected++;
        check_value("yzf_len", cyc, 14);
        @(posedge clk); #1;

        // Backpressure 1,0,0,...
        set_fields(5'b00001, c_x120, '0, '0, '0, '0, 4'b0001);
        start_line(n); run_line(1, 1'b0, cyc); lines_expected++;
        @(posedge clk); #1;

        // Start pulse and input change mid-line.
        set_fields(5'b00001, c_x120, '0, '0, '0, '0, 4'b0001);
        start_line(n); run_line(0, 1'b1, cyc); lines_expected++;
        check_value("disturb_len", cyc, 9);
        repeat (3) begin @(posedge clk); #1; end
        check_value("disturb_no_restart", 32'(bus.o_Busy), 0);

        // Embedded empty bytes, every field, negative E, full rate.
        set_fields(5'b11111, 48'h310032000033, 48'h0, 48'h000037000000, 48'h350000000000,
                   48'h003900390039, 4'b1010);
        start_line(n); run_line(0, 1'b0, cyc); lines_expected++;
        check_value("gaps_len", cyc, n);
        @(posedge clk); #1;

        // Reset while the 4th byte is presented.
        set_fields(5'b00001, c_x120, '0, '0, '0, '0, 4'b0001);
        bus.i_SerialAccept = 1'b1;
        start_line(n);
        repeat (3) begin @(posedge clk); #1; end
        check_value("abort_4th_byte", 32'(bus.o_SerialData), 88);
        dc = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check_value("abort_valid", 32'(bus.o_SerialValid), 0);
        check_value("abort_busy", 32'(bus.o_Busy), 0);
        repeat (4) begin @(posedge clk); #1; end
        check_value("abort_no_done", done_cnt, dc);
        start_line(n); run_line(0, 1'b0, cyc); lines_expected++;
        check_value("after_abort_len", cyc, 9);
        @(posedge clk); #1;

        // Empty line, then a start in the first IDLE cycle.
        set_fields(5'b00000, c_x120, '0, '0, '0, '0, 4'b0001);
        start_line(n); run_line(0, 1'b0, cyc); lines_expected++;
        check_value("empty_len", cyc, 3);
        @(posedge clk); #1;
        check_value("idle_busy", 32'(bus.o_Busy), 0);
        set_fields(5'b00001, c_x120, '0, '0, '0, '0, 4'b0001);
        start_line(n); run_line(0, 1'b0, cyc); lines_expected++;
        check_value("back_to_back_len", cyc, 9);

        // Random lines with random backpressure.
        for (int r = 0; r < 6; r++) begin
            @(posedge clk); #1;
            set_fields(5'($urandom_range(0, 31)), rand_val(), rand_val(), rand_val(),
                       rand_val(), rand_val(), 4'($urandom_range(0, 15)));
            start_line(n); run_line(2, 1'b0, cyc); lines_expected++;
        end

        repeat (3) begin @(posedge clk); #1; end
        check_value("done_total", done_cnt, lines_expected);
        check_value("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
